// File: rtl/reg_pipeline_pkg.sv
// reg_pipeline_pkg
//   Shared helpers for the elastic register pipeline.
//   cnt_op_e / cnt_op() classify how the occupancy counter moves in a cycle
//   given the input-side and output-side transfer strobes.
package reg_pipeline_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    // Both transfers in the same cycle cancel out.
    function automatic cnt_op_e cnt_op(input logic in_xfer, input logic out_xfer);
        cnt_op_e op;
        op = CNT_HOLD;
        if (in_xfer && !out_xfer) op = CNT_INC;
        if (!in_xfer && out_xfer) op = CNT_DEC;
        return op;
    endfunction

endpackage

// File: rtl/reg_pipeline_stage.sv
// pipe_stage
//   One register stage of the elastic pipeline.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     flush               synchronous clear of the valid bit (data held)
//     up_valid, up_data   upstream stage (or producer) output
//     dn_ready            downstream stage (or consumer) ready
//     valid_q, data_q     registered stage contents
//     rdy                 stage can load this cycle (empty or downstream ready)
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output logic             rdy
);

    // An empty stage loads even when downstream is stalled: bubble collapse.
    assign rdy = !valid_q || dn_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (rdy) begin
            valid_q <= up_valid;
            if (up_valid) data_q <= up_data;
        end
    end

endmodule

// File: rtl/reg_pipeline.sv
// reg_pipeline
//   Elastic chain of DEPTH register stages, WIDTH bits each, with a
//   valid/ready handshake on both ends, synchronous flush and an occupancy
//   count.
//   Ports:
//     clk, reset_n               clock, asynchronous active-low reset
//     flush                      drop all held items (blocks transfers)
//     in_valid, in_data, in_ready    producer handshake
//     out_valid, out_data, out_ready consumer handshake (last stage)
//     count                      items currently held, 0..DEPTH
module reg_pipeline
    import reg_pipeline_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             in_xfer, out_xfer;

    // The ready chain is kept in per-stage scalars rather than one vector so
    // the combinational path from out_ready to in_ready is not a self-loop.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn_w;
        logic             rdy_w;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = valid_q[i-1];
            assign up_d = data_q[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_w = out_ready;
        end else begin : g_mid
            assign dn_w = g_stage[i+1].rdy_w;
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .flush    (flush),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (dn_w),
            .valid_q  (valid_q[i]),
            .data_q   (data_q[i]),
            .rdy      (rdy_w)
        );
    end

    assign in_ready  = g_stage[0].rdy_w && !flush;
    assign out_valid = valid_q[DEPTH-1] && !flush;
    assign out_data  = data_q[DEPTH-1];

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        unique case (cnt_op(in_xfer, out_xfer))
            CNT_INC:  count_d = count_q + CW'(1);
            CNT_DEC:  count_d = count_q - CW'(1);
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_reg_pipeline.sv
module tb_reg_pipeline;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    int total = 0;
    int bad   = 0;

    // Scoreboard: items accepted but not yet delivered, oldest first.
    logic [WIDTH-1:0] sb [$];
    int               mcount = 0;

    reg_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive at negedge, record an accepted item.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                       input logic fl, output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = in_valid && in_ready;
        if (acc) sb.push_back(in_data);
    endtask

    task automatic drain();
        logic a;
        int   n;
        n = 0;
        while ((sb.size() != 0 || count != 0) && n < 50) begin
            cyc(1'b0, '0, 1'b1, 1'b0, a);
            n++;
        end
        chk("drain_empty", {31'd0, (sb.size() == 0 && count == 0)}, 32'd1);
    endtask

    // Monitor: reference is an order-preserving store holding at most DEPTH
    // items; with bubble collapsing the pipe refuses input only when full and
    // the consumer is stalled.
    initial begin
        logic [WIDTH-1:0] exp_d;
        logic             ix, ox;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                sb.delete();
                mcount = 0;
            end else begin
                chk("count", 32'(count), 32'(mcount));
                chk("in_ready", {31'd0, in_ready},
                    {31'd0, ((mcount < DEPTH) || out_ready) && !flush});
                if (flush) begin
                    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
                    sb.delete();
                    mcount = 0;
                end else begin
                    ix = in_valid && in_ready;
                    ox = out_valid && out_ready;
                    if (out_valid) begin
                        if (sb.size() == 0) begin
                            chk("out_valid_empty_sb", {31'd0, out_valid}, 32'd0);
                        end else begin
                            exp_d = sb[0];
                            chk("out_data", 32'(out_data), 32'(exp_d));
                            if (ox) void'(sb.pop_front());
                        end
                    end
                    mcount = mcount + int'(ix) - int'(ox);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic [WIDTH-1:0] cur;
        int   acc_n;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Mid-stream reset with three items held.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, a);
        cyc(1'b0, '0, 1'b0, 1'b0, a);
        chk("pre_rst_count", 32'(count), 32'd3);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        #3;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, a);
        chk("post_rst_accept", {31'd0, a}, 32'd1);
        drain();

        // Latency: 8'h11 accepted at edge N shows up after edge N+3.
        for (int j = 0; j < 8; j++) begin
            case (j)
                0: cyc(1'b1, 8'h11, 1'b1, 1'b0, a);
                1: cyc(1'b1, 8'h22, 1'b1, 1'b0, a);
                2: cyc(1'b1, 8'h33, 1'b1, 1'b0, a);
                default: cyc(1'b0, '0, 1'b1, 1'b0, a);
            endcase
            chk("lat_out_valid", {31'd0, out_valid}, {31'd0, (j >= 4 && j <= 6)});
        end
        drain();

        // Back-pressure: only DEPTH items fit while the consumer stalls.
        cur = 8'hA0;
        acc_n = 0;
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, cur, 1'b0, 1'b0, a);
            if (a) begin
                cur++;
                acc_n++;
            end
        end
        chk("bp_accepted", 32'(acc_n), 32'd4);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_data", 32'(out_data), 32'hA0);
        cyc(1'b1, cur, 1'b1, 1'b0, a);
        chk("bp_full_pass_in_ready", {31'd0, a}, 32'd1);
        chk("bp_full_pass_out", 32'(out_data), 32'hA0);
        cur++;
        cyc(1'b1, cur, 1'b1, 1'b0, a);
        drain();

        // Bubble collapse: two items separated by idle cycles pack together.
        cyc(1'b1, 8'h01, 1'b0, 1'b0, a);
        cyc(1'b0, '0, 1'b0, 1'b0, a);
        cyc(1'b0, '0, 1'b0, 1'b0, a);
        cyc(1'b1, 8'h02, 1'b0, 1'b0, a);
        for (int j = 0; j < 3; j++) cyc(1'b0, '0, 1'b0, 1'b0, a);
        chk("bub_count", 32'(count), 32'd2);
        chk("bub_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bub_head", 32'(out_data), 32'h01);
        chk("bub_out_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Flush with a handshake pending on both ends.
        for (int j = 0; j < 3; j++) cyc(1'b1, 8'hF0 + 8'(j), 1'b0, 1'b0, a);
        cyc(1'b0, '0, 1'b0, 1'b0, a);
        chk("fl_pre_count", 32'(count), 32'd3);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1, a);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, a);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_after_valid", {31'd0, out_valid}, 32'd0);

        // Random traffic with occasional flushes.
        for (int j = 0; j < 1000; j++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 63) == 0), a);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, a);
        drain();

        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
